series_host_seq: RTL

Initiator-side sequencer for the Maclaurin series calculation engines (sin, and later cos and exp). It accepts operands on a valid/ready stream and drives the engine's `start`/`done` level handshake. It captures each result into a held output register presented on a valid/ready stream. It sits between the top-level operand source and one series engine (controller unit plus datapath), so upstream logic never touches the engine's handshake.

---
 rtl/series_pkg.sv | 15 +
 rtl/series_host_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/series_pkg.sv
// Shared definitions for the Maclaurin series host sequencer and its engines:
// host state encoding, default operand width and engine iteration count.
package series_pkg;

   localparam int SERIES_W    = 16;
   localparam int SERIES_ITER = 8;

   typedef enum logic [1:0] {
      HOST_IDLE  = 2'd0,
      HOST_ARM   = 2'd1,
      HOST_RUN   = 2'd2,
      HOST_DRAIN = 2'd3
   } host_state_e;

endpackage

// File: rtl/series_host_seq.sv
// Initiator-side sequencer between an operand/result valid-ready stream and one
// series engine's start/done level handshake. Optional job counter: SERIES_HOST_STATS_EN.
module series_host_seq
   import series_pkg::*;
#(
   parameter int W = SERIES_W
`ifdef SERIES_HOST_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_y,
   output logic         eng_start,
   output logic [W-1:0] eng_x,
   input  logic         eng_done,
   input  logic [W-1:0] eng_y
`ifdef SERIES_HOST_STATS_EN
   ,
   output logic [CNT_W-1:0] job_count
`endif
);

   host_state_e  state_q;
   logic [W-1:0] x_q;
   logic         start_q;
   logic         out_valid_q;
   logic         out_valid_d;
   logic [W-1:0] out_y_q;
   logic [W-1:0] out_y_d;
   logic         accept;
   logic         capture_run;
   logic         capture;

   // In IDLE a high eng_done means the engine is free to take a new job.
   assign in_ready = (state_q == HOST_IDLE) & eng_done;
   assign accept   = in_valid & in_ready;

   // Done seen in RUN is completion; done seen in ARM is only the idle level.
   always_comb begin
      capture_run = 1'b0;
      capture     = 1'b0;
      if (state_q == HOST_RUN) begin
         capture_run = eng_done & (~out_valid_q | out_ready);
         capture     = capture_run;
      end else if (state_q == HOST_DRAIN) begin
         capture = out_ready;
      end
      out_valid_d = capture | (out_valid_q & ~out_ready);
      out_y_d     = capture ? eng_y : out_y_q;
   end

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= HOST_IDLE;
         x_q         <= '0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         case (state_q)
            HOST_IDLE: begin
               if (accept) begin
                  x_q     <= in_x;
                  start_q <= 1'b1;
                  state_q <= HOST_ARM;
               end
            end
            HOST_ARM: begin
               if (!eng_done) begin
                  start_q <= 1'b0;
                  state_q <= HOST_RUN;
               end
            end
            HOST_RUN: begin
               if (eng_done) begin
                  state_q <= capture_run ? HOST_IDLE : HOST_DRAIN;
               end
            end
            HOST_DRAIN: begin
               if (out_ready) begin
                  state_q <= HOST_IDLE;
               end
            end
            default: state_q <= HOST_IDLE;
         endcase
      end
   end

   // NOTE: eng_start comes straight from a flop, so there is no combinational
   // path from eng_done back into the engine's start input.
   assign eng_start = start_q;
   assign eng_x     = x_q;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;

`ifdef SERIES_HOST_STATS_EN
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (capture) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign job_count = count_q;
`endif

endmodule
